// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg
// Shared types and helpers for the serial parity framer:
//   out_state_t  - occupancy of the one-word output register (EMPTY/FULL)
//   cnt_w()      - width of the bit counter for a given frame length
//   par_fold()   - folds one more bit (and the odd/even selector) into a parity
package serial_parity_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  function automatic int cnt_w(input int frame_len);
    return $clog2(frame_len);
  endfunction

  function automatic logic par_fold(input logic acc, input logic b, input logic odd);
    return acc ^ b ^ odd;
  endfunction

endpackage

// File: rtl/parity_shift_collector.sv
// parity_shift_collector
// Gathers accepted serial bits into a FRAME_LEN-bit word (first bit = LSB)
// while keeping a running XOR of the bits seen so far.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_beat        an upstream bit is accepted this cycle
//   i_bit         the bit being accepted
//   o_last        the next accepted bit completes the word
//   o_word_done   final bit accepted this cycle (word/parity valid)
//   o_word        completed word including the final bit
//   o_parity      parity of o_word, inverted when ODD=1
module parity_shift_collector
  import serial_parity_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_beat,
  input  logic                 i_bit,
  output logic                 o_last,
  output logic                 o_word_done,
  output logic [FRAME_LEN-1:0] o_word,
  output logic                 o_parity
);

  localparam int            CW   = cnt_w(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0]        r_cnt;
  logic [FRAME_LEN-1:0] r_shift;
  logic                 r_par;

  assign o_last      = (r_cnt == LAST);
  assign o_word_done = i_beat && o_last;
  assign o_parity    = par_fold(r_par, i_bit, ODD);

  // The final bit bypasses the shift register straight into the MSB, so the
  // word is complete in the same cycle the last bit is accepted.
  always_comb begin
    o_word                = r_shift;
    o_word[FRAME_LEN-1]   = i_bit;
  end

  // Bit counter, partial word and running parity; cleared once a word leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else if (i_beat) begin
      if (o_last) begin
        r_cnt   <= '0;
        r_shift <= '0;
        r_par   <= 1'b0;
      end else begin
        r_cnt          <= r_cnt + CW'(1);
        r_shift[r_cnt] <= i_bit;
        r_par          <= r_par ^ i_bit;
      end
    end else begin
      r_cnt   <= r_cnt;
      r_shift <= r_shift;
      r_par   <= r_par;
    end
  end

endmodule

// File: rtl/serial_parity_framer.sv
// serial_parity_framer
// Bit-serial front end: packs FRAME_LEN serial bits into a word, attaches its
// parity and offers it downstream through a one-word output register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   up_valid/up_ready/up_bit serial input handshake and data
//   down_valid/down_ready    word output handshake
//   down_data/down_parity    held word (LSB = first bit) and its parity
module serial_parity_framer
  import serial_parity_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic                 up_bit,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [FRAME_LEN-1:0] down_data,
  output logic                 down_parity
);

  out_state_t           r_state;
  out_state_t           w_state_nxt;
  logic [FRAME_LEN-1:0] r_data;
  logic                 r_parity;

  logic                 w_beat;
  logic                 w_last;
  logic                 w_word_done;
  logic [FRAME_LEN-1:0] w_word;
  logic                 w_parity;

  // Only the word-completing bit can be blocked, and only while the held
  // word is not leaving in the same cycle.
  assign up_ready    = !w_last || (r_state == EMPTY) || down_ready;
  assign w_beat      = up_valid && up_ready;
  assign down_valid  = (r_state == FULL);
  assign down_data   = r_data;
  assign down_parity = r_parity;

  parity_shift_collector #(
    .FRAME_LEN (FRAME_LEN),
    .ODD       (ODD)
  ) u_collector (
    .clk         (clk),
    .rst         (rst),
    .i_beat      (w_beat),
    .i_bit       (up_bit),
    .o_last      (w_last),
    .o_word_done (w_word_done),
    .o_word      (w_word),
    .o_parity    (w_parity)
  );

  // Output register occupancy: a drain and a refill in the same cycle keep it FULL.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: begin
        if (w_word_done) w_state_nxt = FULL;
        else             w_state_nxt = EMPTY;
      end
      FULL: begin
        if (down_ready && !w_word_done) w_state_nxt = EMPTY;
        else                            w_state_nxt = FULL;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // State register and output word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_data   <= '0;
      r_parity <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_word_done) begin
        r_data   <= w_word;
        r_parity <= w_parity;
      end else begin
        r_data   <= r_data;
        r_parity <= r_parity;
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_framer.sv
module tb_serial_parity_framer;

  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up_valid = 1'b0;
  logic          up_bit = 1'b0;
  logic          down_ready = 1'b1;
  logic          up_ready0, up_ready1;
  logic          down_valid0, down_valid1;
  logic [FL-1:0] down_data0, down_data1;
  logic          down_parity0, down_parity1;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  // expected {even_parity, word}
  logic [FL:0] sb[$];

  always #5 clk = ~clk;

  serial_parity_framer #(.FRAME_LEN(FL), .ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready0), .up_bit(up_bit),
    .down_valid(down_valid0), .down_ready(down_ready), .down_data(down_data0),
    .down_parity(down_parity0));

  serial_parity_framer #(.FRAME_LEN(FL), .ODD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready1), .up_bit(up_bit),
    .down_valid(down_valid1), .down_ready(down_ready), .down_data(down_data1),
    .down_parity(down_parity1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted bits and a one-word holding slot.
  initial begin : model
    bit   q_bits[$];
    bit   held;
    bit   exp_ready;
    bit   acc;
    logic [FL-1:0] w;
    held = 1'b0;
    forever begin
      @(negedge clk);
      exp_ready = (q_bits.size() != FL - 1) || !held || down_ready;
      check("up_ready_even", {31'd0, up_ready0}, {31'd0, exp_ready});
      check("up_ready_odd",  {31'd0, up_ready1}, {31'd0, exp_ready});
      check("down_valid_even", {31'd0, down_valid0}, {31'd0, held});
      check("down_valid_odd",  {31'd0, down_valid1}, {31'd0, held});
      if (rst) begin
        q_bits.delete();
        held = 1'b0;
      end else begin
        acc = up_valid && exp_ready;
        if (acc) q_bits.push_back(up_bit);
        if (q_bits.size() == FL) begin
          w = '0;
          foreach (q_bits[i]) w[i] = q_bits[i];
          sb.push_back({1'($countones(w) % 2), w});
          q_bits.delete();
          held = 1'b1;
        end else if (held && down_ready) begin
          held = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each down beat and checks hold stability.
  initial begin : monitor
    logic [FL:0]   e;
    bit            prev_hold;
    logic [FL-1:0] prev_data;
    logic          prev_par0, prev_par1;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_data", {24'd0, down_data0}, {24'd0, prev_data});
          check("hold_par_even", {31'd0, down_parity0}, {31'd0, prev_par0});
          check("hold_par_odd",  {31'd0, down_parity1}, {31'd0, prev_par1});
        end
        if (down_valid0 && down_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_word", {24'd0, down_data0}, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("data_even", {24'd0, down_data0}, {24'd0, e[FL-1:0]});
            check("data_odd",  {24'd0, down_data1}, {24'd0, e[FL-1:0]});
            check("parity_even", {31'd0, down_parity0}, {31'd0, e[FL]});
            check("parity_odd",  {31'd0, down_parity1}, {31'd0, ~e[FL]});
          end
        end
        prev_hold = down_valid0 && !down_ready;
        prev_data = down_data0;
        prev_par0 = down_parity0;
        prev_par1 = down_parity1;
      end
    end
  end

  // Offer one bit until it is accepted (bounded wait).
  task automatic send_bit(input logic b);
    bit ok;
    ok = 1'b0;
    up_valid = 1'b1;
    up_bit   = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = up_ready0;
      if (!ok) stalls++;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [FL-1:0] w);
    for (int i = 0; i < FL; i++) send_bit(w[i]);
    up_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    up_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [FL-1:0] a5;
    int            s0;
    time           t0;
    a5 = 8'hA5;

    // 1. reset with bits offered during reset
    rst = 1'b1; up_valid = 1'b1; up_bit = 1'b1; down_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_down_valid", {31'd0, down_valid0}, 32'd0);
    check("rst_down_data",  {24'd0, down_data0}, 32'd0);
    check("rst_down_parity", {31'd0, down_parity0}, 32'd0);
    check("rst_up_ready",   {31'd0, up_ready0}, 32'd1);
    rst = 1'b0; up_valid = 1'b0;
    idle(2);

    // 2. 1,0,1,1,0,0,0,0 -> 0x0D, valid one cycle after last bit
    send_word(8'h0D);
    check("t2_valid",  {31'd0, down_valid0}, 32'd1);
    check("t2_data",   {24'd0, down_data0}, 32'h0D);
    check("t2_par_even", {31'd0, down_parity0}, 32'd1);
    check("t2_par_odd",  {31'd0, down_parity1}, 32'd0);
    idle(2);

    // 3. all-zero word
    send_word(8'h00);
    check("t3_par_even", {31'd0, down_parity0}, 32'd0);
    check("t3_par_odd",  {31'd0, down_parity1}, 32'd1);
    idle(2);

    // 4. backpressure: FF held while A5 collects, last bit stalls
    down_ready = 1'b0;
    send_word(8'hFF);
    for (int i = 0; i < FL - 1; i++) send_bit(a5[i]);
    up_valid = 1'b1; up_bit = a5[FL-1];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_stall_ready", {31'd0, up_ready0}, 32'd0);
      check("t4_held_data", {24'd0, down_data0}, 32'hFF);
    end
    @(posedge clk);
    #1;
    down_ready = 1'b1;
    send_bit(a5[FL-1]);
    up_valid = 1'b0;
    check("t4_b2b_valid", {31'd0, down_valid0}, 32'd1);
    check("t4_b2b_data", {24'd0, down_data0}, 32'hA5);
    idle(3);

    // 5. 64 random bits streamed with no stall
    s0 = stalls;
    t0 = $time;
    for (int i = 0; i < 64; i++) send_bit(1'($urandom_range(0, 1)));
    up_valid = 1'b0;
    check("t5_stalls", stalls - s0, 32'd0);
    check("t5_cycles", 32'(($time - t0) / 10), 32'd64);
    idle(3);

    // 6. reset mid-word discards the partial bits
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    up_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(8'h81);
    check("t6_data", {24'd0, down_data0}, 32'h81);
    check("t6_par_even", {31'd0, down_parity0}, 32'd0);
    check("t6_par_odd",  {31'd0, down_parity1}, 32'd1);
    idle(4);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
